// File: rtl/pipe_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_datapath_if
// Brief    : Memory and probe bundle between pipe_datapath and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_datapath_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_rdata;
    logic [PC_W-1:0]   pc;
    logic              stall;
    logic              flush;
    logic              wb_we;
    logic [4:0]        wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       instret;

    modport master (
        output imem_addr, dmem_addr, dmem_wdata, dmem_we,
        output pc, stall, flush, wb_we, wb_dest, wb_data, instret,
        input  imem_rdata, dmem_rdata
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
        input  pc, stall, flush, wb_we, wb_dest, wb_data, instret,
        output imem_rdata, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pipe_datapath.sv
`default_nettype none
// ============================================================================
// Module   : pipe_datapath
// Brief    : Five-stage MIPS-subset pipeline with optional ID-stage forwarding,
//            load-use interlock and branch/jump redirect; memories are external.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_datapath #(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FWD_EN   = 1
) (
    input wire              clk,
    input wire              rst,
    pipe_datapath_if.master bus
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [PC_W-1:0] c_J_MASK = PC_W'(28'hFFF_FFFF);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc4;
    } ifid_t;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic              wmem;
        logic              load;
        logic              aluimm;
        logic              beq;
        logic              bne;
        alu_op_t           aluop;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [15:0]       off;
        logic [4:0]        dest;
        logic [PC_W-1:0]   pc4;
    } idex_t;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic              wmem;
        logic              load;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] sdata;
        logic [4:0]        dest;
    } exmem_t;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic [4:0]        dest;
        logic [DATA_W-1:0] data;
    } memwb_t;

    logic [PC_W-1:0]   pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    idex_t             idex_q, idex_d;
    exmem_t            exmem_q, exmem_d;
    memwb_t            memwb_q, memwb_d;
    logic [31:0]       instret_q, instret_d;
    logic [DATA_W-1:0] rf_q [32];

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_dest;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_wreg, w_wmem, w_load, w_aluimm, w_beq, w_bne, w_jmp, w_use_rt;
    alu_op_t           w_aluop;
    logic [DATA_W-1:0] w_rf_rs, w_rf_rt, w_src_a, w_src_b;
    logic              w_wb_we, w_ex_wr, w_mem_wr;
    logic              w_ex_hit_rs, w_ex_hit_rt, w_mem_hit_rs, w_mem_hit_rt;
    logic [DATA_W-1:0] w_mem_val;
    logic              w_stall_raw, w_jmp_id, w_br_taken;
    logic [DATA_W-1:0] w_alu_b, w_alu_res;
    logic [PC_W-1:0]   w_pc_plus4, w_br_target, w_j_target;

    // ---------------- ID: decode ----------------
    always_comb begin
        w_op      = ifid_q.instr[31:26];
        w_rs      = ifid_q.instr[25:21];
        w_rt      = ifid_q.instr[20:16];
        w_rd      = ifid_q.instr[15:11];
        w_funct   = ifid_q.instr[5:0];
        w_imm16   = ifid_q.instr[15:0];
        w_imm_ext = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
        w_wreg    = 1'b0;
        w_wmem    = 1'b0;
        w_load    = 1'b0;
        w_aluimm  = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_jmp     = 1'b0;
        w_use_rt  = 1'b0;
        w_aluop   = ALU_ADD;
        w_dest    = w_rt;
        case (w_op)
            c_OP_RTYPE: begin
                w_use_rt = 1'b1;
                w_dest   = w_rd;
                case (w_funct)
                    c_FN_ADD: begin w_wreg = 1'b1; w_aluop = ALU_ADD; end
                    c_FN_SUB: begin w_wreg = 1'b1; w_aluop = ALU_SUB; end
                    c_FN_AND: begin w_wreg = 1'b1; w_aluop = ALU_AND; end
                    c_FN_OR:  begin w_wreg = 1'b1; w_aluop = ALU_OR;  end
                    c_FN_SLT: begin w_wreg = 1'b1; w_aluop = ALU_SLT; end
                    default:  ;
                endcase
            end
            c_OP_ADDI: begin w_wreg = 1'b1; w_aluimm = 1'b1; end
            c_OP_LW:   begin w_wreg = 1'b1; w_aluimm = 1'b1; w_load = 1'b1; end
            c_OP_SW:   begin w_wmem = 1'b1; w_aluimm = 1'b1; w_use_rt = 1'b1; end
            c_OP_BEQ:  begin w_beq = 1'b1; w_use_rt = 1'b1; end
            c_OP_BNE:  begin w_bne = 1'b1; w_use_rt = 1'b1; end
            c_OP_J:    w_jmp = 1'b1;
            default:   ;
        endcase
    end

    // Register file is write-first: the retiring WB value bypasses the array.
    always_comb begin
        w_wb_we = memwb_q.valid & memwb_q.wreg & (memwb_q.dest != 5'd0) & ~rst;
        w_rf_rs = (w_wb_we && memwb_q.dest == w_rs) ? memwb_q.data : rf_q[w_rs];
        w_rf_rt = (w_wb_we && memwb_q.dest == w_rt) ? memwb_q.data : rf_q[w_rt];
        if (w_rs == 5'd0) w_rf_rs = '0;
        if (w_rt == 5'd0) w_rf_rt = '0;
        w_ex_wr      = idex_q.valid & idex_q.wreg & (idex_q.dest != 5'd0);
        w_mem_wr     = exmem_q.valid & exmem_q.wreg & (exmem_q.dest != 5'd0);
        w_ex_hit_rs  = w_ex_wr & (idex_q.dest == w_rs);
        w_ex_hit_rt  = w_ex_wr & (idex_q.dest == w_rt);
        w_mem_hit_rs = w_mem_wr & (exmem_q.dest == w_rs);
        w_mem_hit_rt = w_mem_wr & (exmem_q.dest == w_rt);
        w_mem_val    = exmem_q.load ? bus.dmem_rdata : exmem_q.res;
    end

    generate
        if (FWD_EN != 0) begin : g_fwd
            always_comb begin
                w_src_a = w_rf_rs;
                w_src_b = w_rf_rt;
                if (w_mem_hit_rs) w_src_a = w_mem_val;
                if (w_mem_hit_rt) w_src_b = w_mem_val;
                if (w_ex_hit_rs && !idex_q.load) w_src_a = w_alu_res;
                if (w_ex_hit_rt && !idex_q.load) w_src_b = w_alu_res;
                w_stall_raw = ifid_q.valid & idex_q.load &
                              (w_ex_hit_rs | (w_use_rt & w_ex_hit_rt));
            end
        end else begin : g_interlock
            always_comb begin
                w_src_a     = w_rf_rs;
                w_src_b     = w_rf_rt;
                w_stall_raw = ifid_q.valid &
                              (w_ex_hit_rs | w_mem_hit_rs |
                               (w_use_rt & (w_ex_hit_rt | w_mem_hit_rt)));
            end
        end
    endgenerate

    // ---------------- EXE: ALU and branch resolution ----------------
    always_comb begin
        w_alu_b = idex_q.aluimm ? idex_q.imm : idex_q.b;
        case (idex_q.aluop)
            ALU_SUB: w_alu_res = idex_q.a - w_alu_b;
            ALU_AND: w_alu_res = idex_q.a & w_alu_b;
            ALU_OR:  w_alu_res = idex_q.a | w_alu_b;
            ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(idex_q.a) < $signed(w_alu_b))};
            default: w_alu_res = idex_q.a + w_alu_b;
        endcase
        w_br_taken  = idex_q.valid & ((idex_q.beq & (idex_q.a == idex_q.b)) |
                                      (idex_q.bne & (idex_q.a != idex_q.b)));
        w_br_target = idex_q.pc4 + {{(PC_W-18){idex_q.off[15]}}, idex_q.off, 2'b00};
        w_jmp_id    = ifid_q.valid & w_jmp;
        w_j_target  = (ifid_q.pc4 & ~c_J_MASK) | PC_W'({ifid_q.instr[25:0], 2'b00});
        w_pc_plus4  = pc_q + PC_W'(4);
    end

    // ---------------- next-state for all pipeline registers ----------------
    always_comb begin
        pc_d         = w_pc_plus4;
        ifid_d.valid = 1'b1;
        ifid_d.instr = bus.imem_rdata;
        ifid_d.pc4   = w_pc_plus4;

        idex_d = '0;
        if (ifid_q.valid) begin
            idex_d.valid  = 1'b1;
            idex_d.wreg   = w_wreg;
            idex_d.wmem   = w_wmem;
            idex_d.load   = w_load;
            idex_d.aluimm = w_aluimm;
            idex_d.beq    = w_beq;
            idex_d.bne    = w_bne;
            idex_d.aluop  = w_aluop;
            idex_d.a      = w_src_a;
            idex_d.b      = w_src_b;
            idex_d.imm    = w_imm_ext;
            idex_d.off    = w_imm16;
            idex_d.dest   = w_dest;
            idex_d.pc4    = ifid_q.pc4;
        end

        exmem_d.valid = idex_q.valid;
        exmem_d.wreg  = idex_q.wreg;
        exmem_d.wmem  = idex_q.wmem;
        exmem_d.load  = idex_q.load;
        exmem_d.res   = w_alu_res;
        exmem_d.sdata = idex_q.b;
        exmem_d.dest  = idex_q.dest;

        memwb_d.valid = exmem_q.valid;
        memwb_d.wreg  = exmem_q.wreg;
        memwb_d.dest  = exmem_q.dest;
        memwb_d.data  = w_mem_val;

        instret_d = instret_q + 32'(memwb_q.valid);

        // A taken branch overrides any stall or jump seen in ID this cycle.
        if (w_br_taken) begin
            pc_d   = w_br_target;
            ifid_d = '0;
            idex_d = '0;
        end else if (w_stall_raw) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end else if (w_jmp_id) begin
            pc_d   = w_j_target;
            ifid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ifid_q    <= '0;
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ifid_q    <= ifid_d;
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            instret_q <= instret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wb_we) rf_q[memwb_q.dest] <= memwb_q.data;
    end

    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.dmem_addr  = exmem_q.res;
    assign bus.dmem_wdata = exmem_q.sdata;
    assign bus.dmem_we    = exmem_q.valid & exmem_q.wmem & ~rst;
    assign bus.stall      = w_stall_raw & ~w_br_taken;
    assign bus.flush      = w_br_taken | (w_jmp_id & ~w_stall_raw);
    assign bus.wb_we      = w_wb_we;
    assign bus.wb_dest    = memwb_q.dest;
    assign bus.wb_data    = memwb_q.data;
    assign bus.instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_datapath
// Brief    : Directed program bench; runs a forwarding and an interlock-only
//            instance side by side against shared instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_datapath;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    pipe_datapath_if #(.DATA_W(32), .PC_W(32)) bus_f ();
    pipe_datapath_if #(.DATA_W(32), .PC_W(32)) bus_i ();

    pipe_datapath #(.DATA_W(32), .PC_W(32), .RESET_PC(32'h0), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .bus(bus_f)
    );
    pipe_datapath #(.DATA_W(32), .PC_W(32), .RESET_PC(32'h0), .FWD_EN(0)) u_ilk (
        .clk(clk), .rst(rst), .bus(bus_i)
    );

    logic [31:0] imem   [128];
    logic [31:0] dmem_f [64];
    logic [31:0] dmem_i [64];
    logic        tb_we    = 1'b0;
    logic [5:0]  tb_waddr = '0;
    logic [31:0] tb_wdata = '0;

    assign bus_f.imem_rdata = imem[bus_f.imem_addr[8:2]];
    assign bus_i.imem_rdata = imem[bus_i.imem_addr[8:2]];
    assign bus_f.dmem_rdata = dmem_f[bus_f.dmem_addr[7:2]];
    assign bus_i.dmem_rdata = dmem_i[bus_i.dmem_addr[7:2]];

    always @(posedge clk) begin
        if (tb_we) begin
            dmem_f[tb_waddr] <= tb_wdata;
            dmem_i[tb_waddr] <= tb_wdata;
        end else begin
            if (bus_f.dmem_we) dmem_f[bus_f.dmem_addr[7:2]] <= bus_f.dmem_wdata;
            if (bus_i.dmem_we) dmem_i[bus_i.dmem_addr[7:2]] <= bus_i.dmem_wdata;
        end
    end

    // Observed write-back history per instance
    logic [31:0] rf_f [32];
    logic [31:0] rf_i [32];
    bit          wr_f [32];
    bit          wr_i [32];
    int stall_f, stall_i, flush_f, dwe_f, first_f;

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn[5:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, tgt[25:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 32; k++) begin
            rf_f[k] = '0; rf_i[k] = '0; wr_f[k] = 1'b0; wr_i[k] = 1'b0;
        end
        stall_f = 0; stall_i = 0; flush_f = 0; dwe_f = 0; first_f = -1;
    endtask

    task automatic clear_imem();
        for (int k = 0; k < 128; k++) imem[k] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_f.wb_we) begin
            if (first_f < 0) first_f = int'(bus_f.wb_dest);
            rf_f[bus_f.wb_dest] = bus_f.wb_data;
            wr_f[bus_f.wb_dest] = 1'b1;
        end
        if (bus_i.wb_we) begin
            rf_i[bus_i.wb_dest] = bus_i.wb_data;
            wr_i[bus_i.wb_dest] = 1'b1;
        end
        if (bus_f.stall)   stall_f++;
        if (bus_i.stall)   stall_i++;
        if (bus_f.flush)   flush_f++;
        if (bus_f.dmem_we) dwe_f++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_obs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_imem();
        clear_obs();

        // ---- dependent ALU chain, both modes ----
        imem[0] = enc_i(8, 0, 1, 5);
        imem[1] = enc_i(8, 1, 2, 3);
        imem[2] = enc_r(1, 2, 3, 32'h20);
        do_reset();
        check("rst_pc",      bus_f.pc, 32'h0);
        check("rst_imem",    bus_f.imem_addr, 32'h0);
        check("rst_instret", bus_f.instret, 32'h0);
        check("rst_wb_we",   32'(bus_f.wb_we), 32'h0);
        check("rst_wb_dest", 32'(bus_f.wb_dest), 32'h0);
        check("rst_wb_data", bus_f.wb_data, 32'h0);
        check("rst_stall",   32'(bus_f.stall), 32'h0);
        check("rst_flush",   32'(bus_f.flush), 32'h0);
        check("rst_dmem_we", 32'(bus_f.dmem_we), 32'h0);
        repeat (4) tick();
        check("c4_wb_we",   32'(bus_f.wb_we), 32'h1);
        check("c4_wb_dest", 32'(bus_f.wb_dest), 32'd1);
        check("c4_wb_data", bus_f.wb_data, 32'd5);
        repeat (3) tick();
        check("s1_instret", bus_f.instret, 32'd3);
        check("s1_stalls",  32'(stall_f), 32'd0);
        check("s1_r1",      rf_f[1], 32'd5);
        check("s1_r2",      rf_f[2], 32'd8);
        check("s1_r3",      rf_f[3], 32'd13);
        repeat (5) tick();
        check("ilk_r1",     rf_i[1], 32'd5);
        check("ilk_r2",     rf_i[2], 32'd8);
        check("ilk_r3",     rf_i[3], 32'd13);
        check("ilk_stalls", 32'(stall_i), 32'd4);

        // ---- load-use then forwarded store ----
        clear_imem();
        imem[0] = enc_i(32'h23, 0, 4, 8);
        imem[1] = enc_i(8, 4, 5, 1);
        imem[2] = enc_i(32'h2B, 0, 5, 12);
        rst = 1'b1;
        tb_we = 1'b1; tb_waddr = 6'd2; tb_wdata = 32'h1234;
        tick();
        tb_we = 1'b0;
        do_reset();
        repeat (10) tick();
        check("lu_stalls", 32'(stall_f), 32'd1);
        check("lu_r4",     rf_f[4], 32'h1234);
        check("lu_r5",     rf_f[5], 32'h1235);
        check("sw_data",   dmem_f[3], 32'h1235);
        check("sw_pulses", 32'(dwe_f), 32'd1);

        // ---- taken beq squashes two fall-through instructions ----
        clear_imem();
        imem[0] = enc_i(4, 0, 0, 2);
        imem[1] = enc_i(8, 0, 6, 1);
        imem[2] = enc_i(8, 0, 7, 2);
        imem[3] = enc_i(8, 0, 8, 3);
        do_reset();
        repeat (2) tick();
        check("beq_flush_c2", 32'(bus_f.flush), 32'h1);
        tick();
        check("beq_pc_c3",    bus_f.pc, 32'd12);
        repeat (6) tick();
        check("beq_flushes",  32'(flush_f), 32'd1);
        check("beq_r6_wr",    32'(wr_f[6]), 32'h0);
        check("beq_r7_wr",    32'(wr_f[7]), 32'h0);
        check("beq_r8",       rf_f[8], 32'd3);

        // ---- jump squashes its delay slot ----
        clear_imem();
        imem[0]  = enc_j(32'h40);
        imem[1]  = enc_i(8, 0, 9, 7);
        imem[64] = enc_i(8, 0, 10, 9);
        do_reset();
        tick();
        check("j_flush_c1", 32'(bus_f.flush), 32'h1);
        tick();
        check("j_pc_c2",    bus_f.pc, 32'h100);
        repeat (6) tick();
        check("j_flushes",  32'(flush_f), 32'd1);
        check("j_r9_wr",    32'(wr_f[9]), 32'h0);
        check("j_first",    32'(first_f), 32'd10);
        check("j_r10",      rf_f[10], 32'd9);
        check("j_instret",  bus_f.instret, 32'd3);

        // ---- remaining ALU ops and taken bne ----
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 5);
        imem[1] = enc_i(8, 0, 2, 8);
        imem[2] = enc_r(1, 2, 11, 32'h22);
        imem[3] = enc_r(11, 1, 12, 32'h2A);
        imem[4] = enc_r(11, 2, 13, 32'h24);
        imem[5] = enc_r(1, 2, 14, 32'h25);
        imem[6] = enc_r(1, 11, 15, 32'h2A);
        imem[7] = enc_i(5, 1, 2, 1);
        imem[8] = enc_i(8, 0, 16, 1);
        imem[9] = enc_i(8, 0, 17, 4);
        do_reset();
        repeat (16) tick();
        check("sub_r11",  rf_f[11], 32'hFFFF_FFFD);
        check("slt_r12",  rf_f[12], 32'd1);
        check("and_r13",  rf_f[13], 32'd8);
        check("or_r14",   rf_f[14], 32'd13);
        check("slt_r15",  rf_f[15], 32'd0);
        check("slt_r15w", 32'(wr_f[15]), 32'h1);
        check("bne_r16",  32'(wr_f[16]), 32'h0);
        check("bne_r17",  rf_f[17], 32'd4);

        // ---- reset while a store is in EXE ----
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 32'h55);
        imem[1] = enc_i(32'h2B, 0, 1, 4);
        do_reset();
        repeat (3) tick();
        rst = 1'b1;
        clear_imem();
        tick();
        check("mid_rst_pc",      bus_f.pc, 32'h0);
        check("mid_rst_instret", bus_f.instret, 32'h0);
        check("mid_rst_dmem_we", 32'(bus_f.dmem_we), 32'h0);
        rst = 1'b0;
        repeat (6) tick();
        check("mid_rst_pulses",  32'(dwe_f), 32'd0);
        check("mid_rst_r1_wr",   32'(wr_f[1]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
